// File: rtl/risc16b_mem_arbiter.sv
// rtl/risc16b_mem_arbiter.sv - CPU-priority cycle-stealing arbiter for the risc16b data memory
module risc16b_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  // CPU data port (never stalled)
  input  logic [15:0] cpu_addr,
  input  logic        cpu_oe,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_we,
  output logic [15:0] cpu_rdata,
  // host request channel
  input  logic        h_req_valid,
  output logic        h_req_ready,
  input  logic [15:0] h_req_addr,
  input  logic [15:0] h_req_wdata,
  input  logic [1:0]  h_req_we,
  // host response channel
  output logic        h_rsp_valid,
  input  logic        h_rsp_ready,
  output logic [15:0] h_rsp_rdata,
  // shared memory port
  output logic [15:0] m_addr,
  output logic [1:0]  m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  // status
  output logic        host_grant,
  output logic        starve
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t      state;
  state_t      state_next;

  logic        cpu_busy;
  logic [15:0] buf_addr;
  logic [15:0] buf_wdata;
  logic [1:0]  buf_we;
  logic [15:0] rsp_rdata;
  logic [CNT_W-1:0] cnt;

  // Loads see memory directly; the arbiter adds no latency on the CPU path.
  assign cpu_rdata = m_rdata;
  assign cpu_busy  = cpu_oe | (cpu_we != 2'b00);

  // Registered outputs are forced to zero while rst is high.
  assign h_rsp_rdata = rst ? 16'h0000 : rsp_rdata;
  assign starve      = !rst && (cnt == LIMIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/grant outputs; the host only gets cycles the CPU leaves idle.
  always_comb begin
    state_next  = state;
    h_req_ready = 1'b0;
    host_grant  = 1'b0;
    h_rsp_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          h_req_ready = 1'b1;
          if (h_req_valid) begin
            state_next = PEND;
          end
        end
        PEND: begin
          if (!cpu_busy) begin
            host_grant = 1'b1;
            state_next = RESP;
          end
        end
        RESP: begin
          h_rsp_valid = 1'b1;
          if (h_rsp_ready) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Memory port mux: CPU by default, request buffer only on a grant cycle.
  always_comb begin
    m_addr  = cpu_addr;
    m_we    = cpu_we;
    m_wdata = cpu_wdata;
    if (host_grant) begin
      m_addr  = buf_addr;
      m_we    = buf_we;
      m_wdata = buf_wdata;
    end
  end

  // Request buffer, response data capture and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_addr  <= 16'h0000;
      buf_wdata <= 16'h0000;
      buf_we    <= 2'b00;
      rsp_rdata <= 16'h0000;
      cnt       <= '0;
    end else begin
      if (state == IDLE && h_req_valid) begin
        buf_addr  <= h_req_addr;
        buf_wdata <= h_req_wdata;
        buf_we    <= h_req_we;
      end
      if (host_grant) begin
        rsp_rdata <= (buf_we == 2'b00) ? m_rdata : 16'h0000;
        cnt       <= '0;
      end else if (state == PEND && cnt != LIMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_risc16b_mem_arbiter.sv
// tb/tb_risc16b_mem_arbiter.sv - directed scoreboard bench for risc16b_mem_arbiter
module tb_risc16b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_oe;
  logic [15:0] cpu_wdata;
  logic [1:0]  cpu_we;
  logic [15:0] cpu_rdata;
  logic        h_req_valid;
  logic        h_req_ready;
  logic [15:0] h_req_addr;
  logic [15:0] h_req_wdata;
  logic [1:0]  h_req_we;
  logic        h_rsp_valid;
  logic        h_rsp_ready;
  logic [15:0] h_rsp_rdata;
  logic [15:0] m_addr;
  logic [1:0]  m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        host_grant;
  logic        starve;

  logic        preload;
  logic [15:0] mem [0:32767];
  logic [15:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  risc16b_mem_arbiter #(.STARVE_LIMIT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_oe(cpu_oe), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_addr(h_req_addr),
    .h_req_wdata(h_req_wdata), .h_req_we(h_req_we),
    .h_rsp_valid(h_rsp_valid), .h_rsp_ready(h_rsp_ready), .h_rsp_rdata(h_rsp_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .host_grant(host_grant), .starve(starve)
  );

  always #5 clk = ~clk;

  // Word memory: asynchronous read, byte-lane write on the clock edge.
  assign m_rdata = mem[m_addr[15:1]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h0000;
      mem[16'h0020] <= 16'hBEEF;
      mem[16'h0030] <= 16'h5A5A;
      mem[16'h0008] <= 16'h00CD;
      mem[16'h0040] <= 16'h1111;
    end else begin
      if (m_we[1]) mem[m_addr[15:1]][15:8] <= m_wdata[15:8];
      if (m_we[0]) mem[m_addr[15:1]][7:0]  <= m_wdata[7:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_oe = 1'b0;
    cpu_we = 2'b00;
  endtask

  // Offer a request for one cycle; it must be accepted immediately (IDLE).
  task automatic accept(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] we, input bit push, input logic [15:0] exp);
    h_req_valid = 1'b1;
    h_req_addr  = a;
    h_req_wdata = d;
    h_req_we    = we;
    #1;
    chk({tag, "_req_ready"}, h_req_ready, 1);
    if (push) exp_q.push_back(exp);
    tick();
    h_req_valid = 1'b0;
  endtask

  // Complete a response handshake in the current cycle and check it against the scoreboard.
  task automatic take_rsp(input string tag);
    logic [15:0] e;
    h_rsp_ready = 1'b1;
    #1;
    chk({tag, "_rsp_valid"}, h_rsp_valid, 1);
    chk({tag, "_req_ready_in_resp"}, h_req_ready, 0);
    chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rsp_rdata"}, h_rsp_rdata, e);
    end
    tick();
    h_rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    cpu_addr = 16'h1111; cpu_wdata = 16'h0000; cpu_idle();
    h_req_valid = 1'b0; h_req_addr = 16'h0000; h_req_wdata = 16'h0000; h_req_we = 2'b00;
    h_rsp_ready = 1'b0;
    tick();

    // Outputs held quiet during reset, memory follows the CPU.
    cpu_oe = 1'b1; h_req_valid = 1'b1;
    #1;
    chk("rst_req_ready", h_req_ready, 0);
    chk("rst_rsp_valid", h_rsp_valid, 0);
    chk("rst_grant", host_grant, 0);
    chk("rst_starve", starve, 0);
    chk("rst_rsp_rdata", h_rsp_rdata, 0);
    chk("rst_m_addr", m_addr, 16'h1111);
    h_req_valid = 1'b0; cpu_idle();
    rst = 1'b0; preload = 1'b0;
    tick();

    // Minimum-latency host read with the CPU idle.
    accept("rd1", 16'h0040, 16'h0000, 2'b00, 1, 16'hBEEF);
    #1;
    chk("rd1_grant", host_grant, 1);
    chk("rd1_m_addr", m_addr, 16'h0040);
    chk("rd1_m_we", m_we, 2'b00);
    chk("rd1_rsp_early", h_rsp_valid, 0);
    tick();
    take_rsp("rd1");

    // Host write held off by five CPU loads.
    accept("wr1", 16'h0020, 16'h1234, 2'b11, 1, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      cpu_oe   = 1'b1;
      cpu_addr = (c == 1) ? 16'h0040 : 16'h0100 + 16'(2 * c);
      #1;
      chk("wr1_blk_grant", host_grant, 0);
      chk("wr1_blk_m_addr", m_addr, (c == 1) ? 16'h0040 : 16'h0100 + 16'(2 * c));
      chk("wr1_blk_m_we", m_we, 2'b00);
      chk("wr1_blk_starve", starve, 0);
      if (c == 1) chk("wr1_cpu_rdata", cpu_rdata, 16'hBEEF);
      tick();
    end
    cpu_idle();
    #1;
    chk("wr1_grant", host_grant, 1);
    chk("wr1_m_addr", m_addr, 16'h0020);
    chk("wr1_m_we", m_we, 2'b11);
    chk("wr1_m_wdata", m_wdata, 16'h1234);
    tick();
    chk("wr1_starve_resp", starve, 0);
    take_rsp("wr1");
    chk("wr1_mem", mem[16'h0010], 16'h1234);

    // Twelve blocked cycles: starve after eight, drops the cycle after the grant.
    accept("stv", 16'h0060, 16'h0000, 2'b00, 1, 16'h5A5A);
    for (int c = 1; c <= 12; c++) begin
      cpu_we = 2'b11; cpu_addr = 16'h0200; cpu_wdata = 16'h0F0F;
      #1;
      chk("stv_blk_grant", host_grant, 0);
      chk("stv_starve", starve, (c >= 9) ? 1 : 0);
      tick();
    end
    cpu_idle();
    #1;
    chk("stv_grant", host_grant, 1);
    chk("stv_starve_at_grant", starve, 1);
    tick();
    chk("stv_starve_after", starve, 0);
    take_rsp("stv");

    // Response back-pressure; the next request waits for IDLE.
    accept("bp", 16'h0040, 16'h0000, 2'b00, 1, 16'hBEEF);
    #1;
    chk("bp_grant", host_grant, 1);
    tick();
    h_req_valid = 1'b1; h_req_addr = 16'h0011; h_req_wdata = 16'hAB00; h_req_we = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_valid", h_rsp_valid, 1);
      chk("bp_hold_rdata", h_rsp_rdata, 16'hBEEF);
      chk("bp_hold_req_ready", h_req_ready, 0);
      tick();
    end
    take_rsp("bp");

    // Byte-lane host write to an odd address.
    accept("byte", 16'h0011, 16'hAB00, 2'b10, 1, 16'h0000);
    #1;
    chk("byte_grant", host_grant, 1);
    chk("byte_m_we", m_we, 2'b10);
    chk("byte_m_addr", m_addr, 16'h0011);
    tick();
    chk("byte_m_we_after", m_we, 2'b00);
    take_rsp("byte");
    chk("byte_mem", mem[16'h0008], 16'hABCD);

    // Reset while PEND and the CPU busy: request dropped, nothing written.
    accept("rp", 16'h0080, 16'hDEAD, 2'b11, 0, 16'h0000);
    cpu_oe = 1'b1; cpu_addr = 16'h0300;
    #1;
    chk("rp_blk_grant", host_grant, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rp_rst_grant", host_grant, 0);
    chk("rp_rst_m_addr", m_addr, 16'h0300);
    chk("rp_rst_req_ready", h_req_ready, 0);
    tick();
    cpu_idle();
    #1;
    chk("rp_rst_idle_grant", host_grant, 0);
    chk("rp_rst_idle_m_we", m_we, 2'b00);
    tick();
    rst = 1'b0;
    #1;
    chk("rp_req_ready", h_req_ready, 1);
    chk("rp_rsp_valid", h_rsp_valid, 0);
    chk("rp_grant", host_grant, 0);
    chk("rp_mem", mem[16'h0040], 16'h1111);

    // Reset while RESP: response dropped.
    accept("rr", 16'h0060, 16'h0000, 2'b00, 0, 16'h0000);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_rst_valid", h_rsp_valid, 0);
    chk("rr_rst_rdata", h_rsp_rdata, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rr_after_valid", h_rsp_valid, 0);
    chk("rr_after_req_ready", h_req_ready, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/risc16b_mem_arbiter.md
Name: risc16b_mem_arbiter

Overview:
- Shares one asynchronous-read, byte-lane-write 16-bit memory between the risc16b CPU data port and a host/debug port.
- The CPU has no stall input, so it always has absolute, zero-latency priority.
- The host gets memory only on cycles where the CPU makes no data access (cycle stealing).
- Sits between the CPU d_* port and the data memory. The host side uses valid/ready request and response channels, holds one outstanding request at a time, and reports starvation.

Parameters:
- STARVE_LIMIT, 8: consecutive blocked PEND cycles after which starve asserts. Legal range 1..255.
- CNT_W, 8: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU data byte address
- cpu_oe  in  1  CPU load strobe
- cpu_wdata  in  16  CPU store data
- cpu_we  in  2  CPU byte-lane write enables; [1] = high byte, [0] = low byte
- cpu_rdata  out  16  load data returned to the CPU
- h_req_valid  in  1  host request valid
- h_req_ready  out  1  host request accepted this cycle
- h_req_addr  in  16  host byte address
- h_req_wdata  in  16  host write data
- h_req_we  in  2  host byte-lane enables; 00 = read
- h_rsp_valid  out  1  host response valid
- h_rsp_ready  in  1  host response consumed
- h_rsp_rdata  out  16  read data; 0 for writes
- m_addr  out  16  memory address
- m_we  out  2  memory byte-lane write enables
- m_wdata  out  16  memory write data
- m_rdata  in  16  memory asynchronous read data
- host_grant  out  1  host owns the memory this cycle
- starve  out  1  host request blocked for at least STARVE_LIMIT cycles

Behaviour:
- cpu_rdata = m_rdata at all times (combinational).
- cpu_busy = cpu_oe | (cpu_we != 00).
- FSM states: IDLE, PEND, RESP. rst forces IDLE and clears every register: request buffer, rsp_rdata, counter.
- IDLE:
  - h_req_ready = !rst.
  - On h_req_valid & h_req_ready: latch addr, wdata and we into the request buffer, go to PEND.
  - A request is never granted in its accept cycle.
- PEND:
  - host_grant = !cpu_busy (combinational).
  - On a grant cycle: m_addr, m_we and m_wdata come from the buffer. For a read (we = 00), m_rdata is captured into rsp_rdata at the clock edge. For a write, rsp_rdata is loaded with 0. Next state is RESP.
  - On a blocked cycle (cpu_busy): stay in PEND, counter += 1, saturating at STARVE_LIMIT.
- RESP:
  - h_rsp_valid = 1; h_rsp_rdata is held stable.
  - On h_rsp_ready, go to IDLE.
  - h_req_ready = 0 throughout RESP. No request is accepted in the same cycle as the response handshake.
- Memory mux when host_grant = 0: m_addr = cpu_addr, m_we = cpu_we, m_wdata = cpu_wdata, in every state. CPU accesses pass through undelayed regardless of host state.
- starve:
  - Registered; starve = (counter == STARVE_LIMIT).
  - Counter clears on the grant edge, so starve drops the cycle after the grant.
  - Counter is 0 in IDLE and RESP.
- Minimum latency: request accepted in cycle 0, grant in cycle 1, h_rsp_valid in cycle 2.
- Simultaneous cpu_oe and cpu_we: both are passed through to memory unchanged. The host is blocked.
- Host address/lane consistency (e.g. odd address with we = 10) is passed through unchecked. The memory interprets byte lanes exactly as for the CPU.
- Reset mid-PEND: the request is dropped and no memory write occurs.
- Reset mid-RESP: the response is dropped; h_rsp_valid = 0 in the cycle after rst.
- Outputs during rst: h_req_ready = 0, h_rsp_valid = 0, host_grant = 0, starve = 0, h_rsp_rdata = 0. m_* follow the CPU.
- h_req_valid is ignored outside IDLE; it must be held by the host until accepted.

Test Plan:
- Idle CPU, mem[0x0040] = 0xBEEF; host read of 0x0040 in cycle 0 -> host_grant = 1 and m_addr = 0x0040 in cycle 1; h_rsp_valid = 1 with h_rsp_rdata = 0xBEEF in cycle 2.
- CPU loads on cycles 1-5, host write 0x1234 to 0x0020 (we = 11) accepted in cycle 0 -> m_addr tracks cpu_addr for cycles 1-5; write commits in cycle 6; h_rsp_valid with rdata 0 in cycle 7; starve stays 0.
- CPU busy for 12 cycles with a host request pending (STARVE_LIMIT = 8) -> starve = 1 after 8 blocked cycles and stays high; host grants in cycle 13; starve = 0 in cycle 14.
- h_rsp_ready held low for 3 cycles in RESP -> h_rsp_valid and h_rsp_rdata stable, h_req_ready = 0; after the handshake, IDLE accepts the next request one cycle later.
- rst asserted in PEND while the CPU is busy, then the CPU goes idle -> no host write reaches memory (m_we equals cpu_we only); h_rsp_valid = 0; h_req_ready = 1 the cycle after rst deasserts.
- Host byte write, we = 10, addr 0x0011, wdata 0xAB00 -> m_we = 10 during the grant cycle only; mem[0x0010] high byte = 0xAB, low byte unchanged.
